maxpool_stream_ctrl: RTL and testbench

- Streaming scheduler for the 2x2 max-pool datapath.
- Accepts one frame of pixels in raster order over a valid/ready interface and buffers the even row in a line buffer.
- On the odd row it assembles each 2x2 patch and drives a `maxpool` instance, then returns one pooled pixel per patch through a registered valid/ready output with backpressure.

---
 rtl/pool_pkg.sv | 25 ++
 rtl/maxpool.sv | 24 ++
 rtl/maxpool_stream_ctrl.sv | 126 ++++++++++++
 tb/tb_maxpool_stream_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 max-pool stream path: pixel width, controller states, patch slice order.
// No logic of its own; imported by the controller and the pooling datapath.
// Not applicable: the package holds no state and applies no backpressure.
package pool_pkg;

    localparam int DATAWIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        POOL  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Slice indices into a packed patch, TL in the top slice
    localparam int TL = 3;
    localparam int TR = 2;
    localparam int BL = 1;
    localparam int BR = 0;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/maxpool.sv
// Unsigned maximum of a packed 2x2 patch.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller registers and flow-controls the result.
module maxpool #(
    parameter int DATAWIDTH = pool_pkg::DATAWIDTH
) (
    input  logic [4*DATAWIDTH-1:0] patch,
    output logic [DATAWIDTH-1:0]   max_data
);
    import pool_pkg::*;

    logic [DATAWIDTH-1:0] tl_px, tr_px, bl_px, br_px;
    logic [DATAWIDTH-1:0] top_max, bot_max;

    assign tl_px = patch[TL*DATAWIDTH +: DATAWIDTH];
    assign tr_px = patch[TR*DATAWIDTH +: DATAWIDTH];
    assign bl_px = patch[BL*DATAWIDTH +: DATAWIDTH];
    assign br_px = patch[BR*DATAWIDTH +: DATAWIDTH];

    assign top_max  = (tl_px >= tr_px) ? tl_px : tr_px;
    assign bot_max  = (bl_px >= br_px) ? bl_px : br_px;
    assign max_data = (top_max >= bot_max) ? top_max : bot_max;

endmodule

// File: rtl/maxpool_stream_ctrl.sv
// Streams one raster frame in, buffers the even row, emits one 2x2 max per patch on the odd row.
// Latency: result registered one cycle after the bottom-right pixel handshake.
// Backpressure: input stalls in POOL while the output register is full and out_ready is low.
module maxpool_stream_ctrl #(
    parameter int DATAWIDTH = pool_pkg::DATAWIDTH,
    parameter int IMG_W     = 8,
    parameter int IMG_H     = 8
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 done
);
    import pool_pkg::*;

    localparam int COL_W = cnt_w(IMG_W);
    localparam int RP_W  = cnt_w(IMG_H / 2);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [RP_W-1:0]  RP_LAST  = RP_W'(IMG_H / 2 - 1);

    state_t                 state, state_nxt;
    logic [COL_W-1:0]       col, col_even;
    logic [RP_W-1:0]        row_pair;
    logic [DATAWIDTH-1:0]   linebuf [IMG_W];
    logic [DATAWIDTH-1:0]   left_reg;
    logic [DATAWIDTH-1:0]   pool_max;
    logic [4*DATAWIDTH-1:0] patch;
    logic                   in_fire, out_fire, row_end, last_pair, load;

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign row_end   = (col == COL_LAST);
    assign last_pair = (row_pair == RP_LAST);
    assign load      = (state == POOL) && in_fire && col[0];
    assign busy      = (state != IDLE);
    assign col_even  = col & ~COL_W'(1);

    assign patch[TL*DATAWIDTH +: DATAWIDTH] = linebuf[col_even];
    assign patch[TR*DATAWIDTH +: DATAWIDTH] = linebuf[col];
    assign patch[BL*DATAWIDTH +: DATAWIDTH] = left_reg;
    assign patch[BR*DATAWIDTH +: DATAWIDTH] = in_data;

    maxpool #(.DATAWIDTH(DATAWIDTH)) u_maxpool (
        .patch    (patch),
        .max_data (pool_max)
    );

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = FILL;
            end
            FILL: begin
                in_ready = 1'b1;
                if (in_fire && row_end) state_nxt = POOL;
            end
            POOL: begin
                // Only take a pixel if its result (if any) has a free output slot
                in_ready = !out_valid || out_ready;
                if (in_fire && row_end) state_nxt = last_pair ? DRAIN : FILL;
            end
            DRAIN: begin
                if (out_fire && out_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            col      <= '0;
            row_pair <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                col      <= '0;
                row_pair <= '0;
            end
        end else if (in_fire) begin
            col <= row_end ? '0 : col + COL_W'(1);
            if (state == POOL && row_end && !last_pair) row_pair <= row_pair + RP_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (state == FILL && in_fire) linebuf[col] <= in_data;
        if (state == POOL && in_fire && !col[0]) left_reg <= in_data;
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= out_fire && out_last;
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= pool_max;
                out_last  <= row_end && last_pair;
            end else if (out_fire) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_maxpool_stream_ctrl.sv
// Scoreboard bench for a 4x4 frame: expected maxima queued as bottom-right pixels are accepted,
// checked against each output handshake, plus stall hold, done/busy timing, mid-frame start and reset.
module tb_maxpool_stream_ctrl;
    localparam int DW = 16;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int NPIX = W * H;
    localparam int NRES = (W / 2) * (H / 2);

    logic          CLK = 1'b0;
    logic          rst, start, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic          busy, in_ready, out_valid, out_last, done;
    logic [DW-1:0] out_data;

    maxpool_stream_ctrl #(.DATAWIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
        .CLK       (CLK),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          last;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] pix [NPIX];
    int            checks = 0;
    int            failures = 0;
    int            results = 0;
    int            dones = 0;
    int            ready_mode = 0;
    int            rphase = 0;
    bit            done_exp = 1'b0;
    bit            held_vld = 1'b0;
    logic [DW-1:0] held;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] max4(input logic [DW-1:0] a, b, c, d);
        logic [DW-1:0] m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // out_ready pattern: mode 0 always ready, mode 1 repeats 1,0,0,1
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (ready_mode == 0) begin
                out_ready = 1'b1;
            end else begin
                out_ready = (rphase % 4 == 0) || (rphase % 4 == 3);
                rphase++;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (rst) begin
                held_vld = 1'b0;
                done_exp = 1'b0;
            end else begin
                if (done_exp) begin
                    check_eq("done_pulse", {31'd0, done}, 32'd1);
                    check_eq("busy_after_done", {31'd0, busy}, 32'd0);
                    done_exp = 1'b0;
                    dones++;
                end else if (done) begin
                    check_eq("done_spurious", {31'd0, done}, 32'd0);
                end
                if (held_vld) begin
                    check_eq("stall_hold_valid", {31'd0, out_valid}, 32'd1);
                    check_eq("stall_hold_data", {16'd0, out_data}, {16'd0, held});
                end
                held_vld = out_valid && !out_ready;
                held     = out_data;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_output", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("out_data", {16'd0, out_data}, {16'd0, e.d});
                        check_eq("out_last", {31'd0, out_last}, {31'd0, e.last});
                        results++;
                        if (e.last) done_exp = 1'b1;
                    end
                end
            end
        end
    end

    // Sends pixels of pix[] after a start pulse; stops early once stop_after pixels are accepted
    task automatic send_frame(input bit mid_start, input int stop_after);
        bit acc;
        int r, c;
        exp_t e;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        for (int i = 0; i < NPIX; i++) begin
            if (i == stop_after) break;
            r = i / W;
            c = i % W;
            in_valid = 1'b1;
            in_data  = pix[i];
            if (mid_start && i == 9) start = 1'b1;
            acc = 1'b0;
            for (int t = 0; t < 200 && !acc; t++) begin
                @(negedge CLK);
                if ((r % 2 == 1) && out_valid && !out_ready)
                    check_eq("in_ready_stall", {31'd0, in_ready}, 32'd0);
                acc = in_ready;
                if (acc && (r % 2 == 1) && (c % 2 == 1)) begin
                    e.d    = max4(pix[(r-1)*W + c-1], pix[(r-1)*W + c], pix[r*W + c-1], pix[r*W + c]);
                    e.last = (r == H - 1) && (c == W - 1);
                    exp_q.push_back(e);
                end
                @(posedge CLK);
                #1;
                start = 1'b0;
            end
            if (!acc) check_eq("in_accept_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input int mode, input bit mid_start);
        int r0, d0;
        ready_mode = mode;
        r0 = results;
        d0 = dones;
        send_frame(mid_start, NPIX);
        for (int t = 0; t < 300 && dones == d0; t++) @(negedge CLK);
        if (dones == d0) check_eq("done_timeout", 32'd0, 32'd1);
        check_eq("results_per_frame", results - r0, NRES);
        check_eq("queue_empty", exp_q.size(), 32'd0);
        @(negedge CLK);
        check_eq("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_data", {16'd0, out_data}, 32'd0);
        check_eq("rst_out_last", {31'd0, out_last}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge CLK);
        #1;
        rst = 1'b0;

        for (int i = 0; i < NPIX; i++) pix[i] = DW'(i);
        run_frame(0, 1'b0);
        run_frame(1, 1'b0);

        for (int i = 0; i < NPIX; i++) pix[i] = 16'd1;
        pix[0] = 16'd9; pix[3] = 16'd9; pix[12] = 16'd9; pix[15] = 16'd9;
        run_frame(0, 1'b0);

        for (int i = 0; i < NPIX; i++) pix[i] = 16'h0042;
        run_frame(1, 1'b0);

        for (int i = 0; i < NPIX; i++) pix[i] = 16'h0000;
        pix[0] = 16'h7FFF; pix[1] = 16'hFFFF; pix[4] = 16'h0000; pix[5] = 16'h8000;
        run_frame(1, 1'b0);

        for (int i = 0; i < NPIX; i++) pix[i] = DW'(i);
        run_frame(0, 1'b1);

        ready_mode = 0;
        send_frame(1'b0, 6);
        rst = 1'b1;
        #1;
        check_eq("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        check_eq("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        exp_q.delete();
        @(posedge CLK);
        #1;
        rst = 1'b0;
        run_frame(0, 1'b0);

        repeat (3) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
